// File: rtl/sequence_checker.sv
// sequence_checker: receive-side monitor that locks onto a programmed count sequence and checks every sample.
// Latency: the response to a sample at edge N (lock, pos, expected, mismatch, err_count) is visible after edge N.
// Backpressure: none; it only observes the stream. Cycles with i_count_valid=0 are ignored and change no state.
//
// Ports:
//   i_clk          rising-edge clock
//   i_clear_n      async active-low reset (release takes effect at the next i_clk edge)
//   i_count        observed counter value, WIDTH bits
//   i_count_valid  sample i_count this cycle
//   o_locked       checker is tracking the sequence (state == LOCKED)
//   o_expected     SEQ[o_pos]; only meaningful while locked
//   o_pos          index of the next expected element
//   o_mismatch     one-cycle pulse: the last valid sample failed its check
//   o_err_count    total mismatches, saturating at 255
module sequence_checker #(
  parameter int                        WIDTH      = 3,
  parameter int                        SEQ_LEN    = 8,
  parameter logic [WIDTH*SEQ_LEN-1:0]  SEQ        = 24'h8F1EA8,
  parameter int                        MISS_LIMIT = 2
) (
  input  logic                                       i_clk,
  input  logic                                       i_clear_n,
  input  logic [WIDTH-1:0]                           i_count,
  input  logic                                       i_count_valid,
  output logic                                       o_locked,
  output logic [WIDTH-1:0]                           o_expected,
  output logic [((SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1)-1:0] o_pos,
  output logic                                       o_mismatch,
  output logic [7:0]                                 o_err_count
);

  localparam int POS_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int MISS_W = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT + 1) : 1;

  localparam logic [POS_W-1:0]  LAST_POS = POS_W'(SEQ_LEN - 1);
  localparam logic [MISS_W-1:0] MISS_TOP = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic [POS_W-1:0]   r_pos;
  logic [WIDTH-1:0]   r_expected;
  logic [MISS_W-1:0]  r_miss;
  logic               r_locked;
  logic               r_mismatch;
  logic [7:0]         r_err_count;

  // Search-side parallel compare against every element.
  logic               w_hit;
  logic [POS_W-1:0]   w_hit_idx;
  // Position following the hit (search) and following r_pos (tracking).
  logic [POS_W-1:0]   w_hit_next;
  logic [POS_W-1:0]   w_pos_next;
  logic [7:0]         w_err_inc;

  function automatic logic [WIDTH-1:0] seq_elem(input logic [POS_W-1:0] p);
    logic [WIDTH-1:0] e;
    e = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (p == POS_W'(k)) begin
        e = SEQ[k*WIDTH +: WIDTH];
      end
    end
    return e;
  endfunction

  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] p);
    return (p == LAST_POS) ? '0 : p + POS_W'(1);
  endfunction

  // Elements are unique, so at most one index matches; the loop simply keeps it.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (i_count == SEQ[i*WIDTH +: WIDTH]) begin
        w_hit     = 1'b1;
        w_hit_idx = POS_W'(i);
      end
    end
  end

  assign w_hit_next = step_pos(w_hit_idx);
  assign w_pos_next = step_pos(r_pos);
  assign w_err_inc  = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

  always_ff @(posedge i_clk or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_state     <= ST_SEARCH;
      r_pos       <= '0;
      r_expected  <= SEQ[WIDTH-1:0];
      r_miss      <= '0;
      r_locked    <= 1'b0;
      r_mismatch  <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      r_mismatch <= 1'b0;
      if (i_count_valid) begin
        case (r_state)
          ST_SEARCH: begin
            if (w_hit) begin
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
              r_pos      <= w_hit_next;
              r_expected <= seq_elem(w_hit_next);
              r_miss     <= '0;
            end else begin
              r_mismatch  <= 1'b1;
              r_err_count <= w_err_inc;
            end
          end
          ST_LOCKED: begin
            if (i_count == r_expected) begin
              r_pos      <= w_pos_next;
              r_expected <= seq_elem(w_pos_next);
              r_miss     <= '0;
            end else begin
              r_mismatch  <= 1'b1;
              r_err_count <= w_err_inc;
              if (r_miss == MISS_TOP) begin
                // Too many misses in a row: give up and search again from scratch.
                r_state    <= ST_SEARCH;
                r_locked   <= 1'b0;
                r_pos      <= '0;
                r_expected <= SEQ[WIDTH-1:0];
                r_miss     <= '0;
              end else begin
                // Still advance so one corrupted value does not desynchronise us.
                r_miss     <= r_miss + MISS_W'(1);
                r_pos      <= w_pos_next;
                r_expected <= seq_elem(w_pos_next);
              end
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
            r_pos    <= '0;
            r_miss   <= '0;
          end
        endcase
      end
    end
  end

  assign o_locked    = r_locked;
  assign o_expected  = r_expected;
  assign o_pos       = r_pos;
  assign o_mismatch  = r_mismatch;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_sequence_checker.sv
// tb_sequence_checker: directed table-driven bench for sequence_checker, plus hand-written corner sequences.
// A second instance with 4-bit values exercises sample values that belong to no element.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time unit after the next rising edge.
module tb_sequence_checker;

  logic       clk;
  logic       clear_n;
  logic [2:0] count;
  logic       count_valid;
  logic       locked;
  logic [2:0] expected;
  logic [2:0] pos;
  logic       mismatch;
  logic [7:0] err_count;

  logic [3:0] count4;
  logic       count_valid4;
  logic       locked4;
  logic [3:0] expected4;
  logic [2:0] pos4;
  logic       mismatch4;
  logic [7:0] err_count4;

  int checks = 0;
  int errors = 0;

  logic [2:0] seq_tab [8] = '{3'd0, 3'd5, 3'd2, 3'd7, 3'd1, 3'd6, 3'd3, 3'd4};

  sequence_checker u_dut (
    .i_clk         (clk),
    .i_clear_n     (clear_n),
    .i_count       (count),
    .i_count_valid (count_valid),
    .o_locked      (locked),
    .o_expected    (expected),
    .o_pos         (pos),
    .o_mismatch    (mismatch),
    .o_err_count   (err_count)
  );

  sequence_checker #(
    .WIDTH      (4),
    .SEQ_LEN    (8),
    .SEQ        (32'h43617250),
    .MISS_LIMIT (2)
  ) u_dut4 (
    .i_clk         (clk),
    .i_clear_n     (clear_n),
    .i_count       (count4),
    .i_count_valid (count_valid4),
    .o_locked      (locked4),
    .o_expected    (expected4),
    .o_pos         (pos4),
    .o_mismatch    (mismatch4),
    .o_err_count   (err_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [2:0] cnt;
    logic       e_locked;
    logic [2:0] e_pos;
    logic [2:0] e_expected;
    logic       e_mismatch;
    logic [7:0] e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [2:0] c, input logic l, input logic [2:0] p,
                     input logic [2:0] e, input logic m, input logic [7:0] ec);
    vec_t t;
    t.vld = v; t.cnt = c; t.e_locked = l; t.e_pos = p;
    t.e_expected = e; t.e_mismatch = m; t.e_err = ec;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus and wait until just after the edge that samples it.
  task automatic cyc(input logic v, input logic [2:0] c);
    count_valid = v;
    count       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " locked"},    32'(locked),    32'd0);
    chk({tag, " pos"},       32'(pos),       32'd0);
    chk({tag, " expected"},  32'(expected),  32'd0);
    chk({tag, " mismatch"},  32'(mismatch),  32'd0);
    chk({tag, " err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    int p;

    clear_n      = 1'b0;
    count        = 3'd0;
    count_valid  = 1'b0;
    count4       = 4'd0;
    count_valid4 = 1'b0;

    // Test 1 stream, then test 3 single corruption, test 5 gaps, test 4 lock loss.
    add(1, 3'd0, 1, 3'd1, 3'd5, 0, 8'd0);
    add(1, 3'd5, 1, 3'd2, 3'd2, 0, 8'd0);
    add(1, 3'd2, 1, 3'd3, 3'd7, 0, 8'd0);
    add(1, 3'd7, 1, 3'd4, 3'd1, 0, 8'd0);
    add(1, 3'd1, 1, 3'd5, 3'd6, 0, 8'd0);
    add(1, 3'd6, 1, 3'd6, 3'd3, 0, 8'd0);
    add(1, 3'd3, 1, 3'd7, 3'd4, 0, 8'd0);
    add(1, 3'd4, 1, 3'd0, 3'd0, 0, 8'd0);
    add(1, 3'd0, 1, 3'd1, 3'd5, 0, 8'd0);
    add(1, 3'd5, 1, 3'd2, 3'd2, 0, 8'd0);
    add(1, 3'd2, 1, 3'd3, 3'd7, 0, 8'd0);
    add(1, 3'd7, 1, 3'd4, 3'd1, 0, 8'd0);
    add(1, 3'd3, 1, 3'd5, 3'd6, 1, 8'd1);
    add(1, 3'd6, 1, 3'd6, 3'd3, 0, 8'd1);
    add(0, 3'd3, 1, 3'd6, 3'd3, 0, 8'd1);
    add(0, 3'd5, 1, 3'd6, 3'd3, 0, 8'd1);
    add(0, 3'd0, 1, 3'd6, 3'd3, 0, 8'd1);
    add(1, 3'd3, 1, 3'd7, 3'd4, 0, 8'd1);
    add(1, 3'd4, 1, 3'd0, 3'd0, 0, 8'd1);
    add(1, 3'd1, 1, 3'd1, 3'd5, 1, 8'd2);
    add(1, 3'd1, 0, 3'd0, 3'd0, 1, 8'd3);
    add(1, 3'd5, 1, 3'd2, 3'd2, 0, 8'd3);
    add(0, 3'd5, 1, 3'd2, 3'd2, 0, 8'd3);
    // Miss counter resets on a good sample: bad, good, bad keeps lock.
    add(1, 3'd0, 1, 3'd3, 3'd7, 1, 8'd4);
    add(1, 3'd7, 1, 3'd4, 3'd1, 0, 8'd4);
    add(1, 3'd0, 1, 3'd5, 3'd6, 1, 8'd5);
    add(1, 3'd6, 1, 3'd6, 3'd3, 0, 8'd5);

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    chk("rst locked4", 32'(locked4), 32'd0);
    chk("rst err4",    32'(err_count4), 32'd0);
    clear_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      cyc(vecs[k].vld, vecs[k].cnt);
      chk($sformatf("vec%0d locked", k),    32'(locked),    32'(vecs[k].e_locked));
      chk($sformatf("vec%0d pos", k),       32'(pos),       32'(vecs[k].e_pos));
      chk($sformatf("vec%0d expected", k),  32'(expected),  32'(vecs[k].e_expected));
      chk($sformatf("vec%0d mismatch", k),  32'(mismatch),  32'(vecs[k].e_mismatch));
      chk($sformatf("vec%0d err_count", k), 32'(err_count), 32'(vecs[k].e_err));
    end

    // Test 2: lock mid-sequence, and unknown values in search on the 4-bit instance.
    clear_n = 1'b0;
    #1;
    chk_reset_vals("rst2");
    clear_n      = 1'b1;
    count_valid4 = 1'b1;
    count4       = 4'd9;
    cyc(1, 3'd7);
    chk("mid locked",   32'(locked),   32'd1);
    chk("mid pos",      32'(pos),      32'd4);
    chk("mid expected", 32'(expected), 32'd1);
    chk("mid mismatch", 32'(mismatch), 32'd0);
    chk("w4 miss locked",   32'(locked4),    32'd0);
    chk("w4 miss mismatch", 32'(mismatch4),  32'd1);
    chk("w4 miss err",      32'(err_count4), 32'd1);
    chk("w4 miss pos",      32'(pos4),       32'd0);
    count4 = 4'd7;
    cyc(0, 3'd0);
    count_valid4 = 1'b0;
    chk("w4 lock locked",   32'(locked4),    32'd1);
    chk("w4 lock pos",      32'(pos4),       32'd4);
    chk("w4 lock expected", 32'(expected4),  32'd1);
    chk("w4 lock mismatch", 32'(mismatch4),  32'd0);
    chk("w4 lock err",      32'(err_count4), 32'd1);

    // Test 6: saturation. Alternate bad/good so lock is kept throughout.
    clear_n = 1'b0;
    #1;
    clear_n = 1'b1;
    cyc(1, 3'd0);
    p = 1;
    for (int n = 1; n <= 260; n++) begin
      cyc(1, seq_tab[p] ^ 3'd1);
      p = (p + 1) % 8;
      if (mismatch !== 1'b1 || locked !== 1'b1) begin
        chk($sformatf("sat bad%0d mm/locked", n), 32'({mismatch, locked}), 32'h3);
      end
      if (n == 254) chk("sat err 254", 32'(err_count), 32'd254);
      if (n == 255) chk("sat err 255", 32'(err_count), 32'd255);
      cyc(1, seq_tab[p]);
      p = (p + 1) % 8;
    end
    chk("sat err final", 32'(err_count), 32'd255);
    chk("sat locked",    32'(locked),    32'd1);
    chk("sat pos",       32'(pos),       32'(p));
    cyc(1, seq_tab[p] ^ 3'd2);
    chk("sat hold mismatch", 32'(mismatch),  32'd1);
    chk("sat hold err",      32'(err_count), 32'd255);

    // Async reset between edges: outputs clear with no clock edge.
    #2;
    clear_n = 1'b0;
    #1;
    chk_reset_vals("async");
    count_valid = 1'b0;
    #1;
    clear_n = 1'b1;
    cyc(0, 3'd0);
    chk_reset_vals("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
